// File: rtl/game_button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: per-channel FSM states
// and the fixed mapping of board buttons onto bit positions.
package game_button_conditioner_pkg;

  typedef enum logic [4:0] {
    IDLE         = 5'b00001,
    WAIT_PRESS   = 5'b00010,
    PULSE        = 5'b00100,
    HELD         = 5'b01000,
    WAIT_RELEASE = 5'b10000
  } btn_state_e;

  localparam int BTN_C    = 0;
  localparam int BTN_L    = 1;
  localparam int BTN_R    = 2;
  localparam int BTN_D    = 3;
  localparam int NUM_BTNS = 4;

endpackage

// File: rtl/game_button_conditioner_btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM and a shared counter
// pair producing a press pulse, a debounced level and auto-repeat pulses.
module btn_debounce
  import game_button_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o,
  output logic level_o,
  output logic repeat_o
);

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  btn_state_e       state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] deb_q;
  logic [CNT_W-1:0] rep_q;
  logic             first_q;
  logic             pulse_q;
  logic             level_q;
  logic             repeat_q;

  logic             btn_sync;
  logic             rep_wrap;
  logic             first_d;
  logic [CNT_W-1:0] rep_last;
  logic [CNT_W-1:0] rep_d;
  logic [CNT_W-1:0] rep_last_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Repeat timer advance for one HELD cycle: the first interval is the long
  // delay, every later one is the period.
  // NOTE: every signal written here is assigned on every pass, so no latch.
  always_comb begin
    btn_sync   = sync_q[1];
    rep_last   = first_q ? DELAY_LAST : PERIOD_LAST;
    rep_wrap   = (rep_q == rep_last);
    rep_d      = rep_wrap ? '0 : sat_inc(rep_q);
    first_d    = first_q & ~rep_wrap;
    rep_last_d = first_d ? DELAY_LAST : PERIOD_LAST;
  end

  // NOTE: all state uses non-blocking assignments so every flop sees the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      deb_q    <= '0;
      rep_q    <= '0;
      first_q  <= 1'b0;
      pulse_q  <= 1'b0;
      level_q  <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      pulse_q  <= 1'b0;
      repeat_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          deb_q <= '0;
          if (btn_sync) state_q <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!btn_sync) begin
            state_q <= IDLE;
            deb_q   <= '0;
          end else if (deb_q == DEB_LAST) begin
            state_q  <= PULSE;
            deb_q    <= '0;
            pulse_q  <= 1'b1;
            repeat_q <= 1'b1;
            level_q  <= 1'b1;
          end else begin
            deb_q <= sat_inc(deb_q);
          end
        end
        PULSE: begin
          state_q  <= HELD;
          rep_q    <= '0;
          first_q  <= 1'b1;
          repeat_q <= (DELAY_LAST == '0);
        end
        HELD: begin
          // The cycle just spent in HELD always counts toward the repeat timer.
          rep_q   <= rep_d;
          first_q <= first_d;
          if (btn_sync) begin
            repeat_q <= (rep_d == rep_last_d);
          end else begin
            state_q <= WAIT_RELEASE;
            deb_q   <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (btn_sync) begin
            state_q  <= HELD;
            deb_q    <= '0;
            repeat_q <= rep_wrap;
          end else if (deb_q == DEB_LAST) begin
            state_q <= IDLE;
            deb_q   <= '0;
            level_q <= 1'b0;
          end else begin
            deb_q <= sat_inc(deb_q);
          end
        end
        default: begin
          state_q <= IDLE;
          deb_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_o  = pulse_q;
  assign level_o  = level_q;
  assign repeat_o = repeat_q;

endmodule

// File: rtl/game_button_conditioner.sv
// Four independent button channels turning raw board buttons into the game
// FSM's Select / selectLeft / selectRight / Quit pulses plus levels and repeats.
module game_button_conditioner
  import game_button_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnC,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnD,
  output logic       Select,
  output logic       selectLeft,
  output logic       selectRight,
  output logic       Quit,
  output logic [3:0] dpb,
  output logic [3:0] mcen
);

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] scen;

  assign raw[BTN_C] = BtnC;
  assign raw[BTN_L] = BtnL;
  assign raw[BTN_R] = BtnR;
  assign raw[BTN_D] = BtnD;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_debounce (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .btn_i   (raw[i]),
      .pulse_o (scen[i]),
      .level_o (dpb[i]),
      .repeat_o(mcen[i])
    );
  end

  assign Select      = scen[BTN_C];
  assign selectLeft  = scen[BTN_L];
  assign selectRight = scen[BTN_R];
  assign Quit        = scen[BTN_D];

endmodule

// File: tb/tb_game_button_conditioner.sv
// Self-checking bench: directed scenarios plus random bouncing buttons, all
// compared cycle by cycle against a run-length based behavioural model.
module tb_game_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       BtnC = 1'b0, BtnL = 1'b0, BtnR = 1'b0, BtnD = 1'b0;
  logic       Select, selectLeft, selectRight, Quit;
  logic [3:0] dpb, mcen;

  int vectors = 0;
  int errors  = 0;

  always #5 Clk = ~Clk;

  game_button_conditioner #(
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .CNT_W        (26)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .BtnC       (BtnC),
    .BtnL       (BtnL),
    .BtnR       (BtnR),
    .BtnD       (BtnD),
    .Select     (Select),
    .selectLeft (selectLeft),
    .selectRight(selectRight),
    .Quit       (Quit),
    .dpb        (dpb),
    .mcen       (mcen)
  );

  wire [11:0] obs = {Quit, selectRight, selectLeft, Select, dpb, mcen};

  // Behavioural model: a button is either released, in its one-cycle press
  // pulse, held (counting held cycles) or waiting out a release debounce.
  typedef enum int {M_UP, M_PRESS, M_HELD, M_RELEASING} mode_e;
  mode_e mode [4];
  int    sh1 [4];
  int    sh2 [4];
  int    run [4];
  int    held[4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      mode[i] = M_UP; sh1[i] = 0; sh2[i] = 0; run[i] = 0; held[i] = 0;
    end
  end

  task automatic model_edge(input logic [3:0] raw, input logic rst);
    int s;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mode[i] = M_UP; sh1[i] = 0; sh2[i] = 0; run[i] = 0; held[i] = 0;
      end else begin
        s = sh2[i];
        sh2[i] = sh1[i];
        sh1[i] = int'(raw[i]);
        case (mode[i])
          M_UP: begin
            run[i] = (s != 0) ? run[i] + 1 : 0;
            if (run[i] == DEB + 1) begin mode[i] = M_PRESS; run[i] = 0; end
          end
          M_PRESS: begin mode[i] = M_HELD; held[i] = 1; end
          M_HELD: begin
            if (s == 0) begin mode[i] = M_RELEASING; run[i] = 1; end
            else held[i]++;
          end
          default: begin
            if (s != 0) begin mode[i] = M_HELD; held[i]++; run[i] = 0; end
            else begin
              run[i]++;
              if (run[i] == DEB + 1) begin mode[i] = M_UP; run[i] = 0; end
            end
          end
        endcase
      end
    end
  endtask

  function automatic logic [11:0] model_out();
    logic [3:0] sc, lv, rp;
    for (int i = 0; i < 4; i++) begin
      sc[i] = (mode[i] == M_PRESS);
      lv[i] = (mode[i] != M_UP);
      rp[i] = (mode[i] == M_PRESS) ||
              (mode[i] == M_HELD && held[i] >= RD && ((held[i] - RD) % RP) == 0);
    end
    return {sc, lv, rp};
  endfunction

  // One clock: inputs seen at the edge feed the model, outputs settle by #1.
  task automatic tick();
    logic [3:0] raw;
    logic       rst;
    raw = {BtnD, BtnR, BtnL, BtnC};
    rst = Reset;
    @(posedge Clk);
    model_edge(raw, rst);
    #1;
  endtask

  task automatic do_reset();
    {BtnC, BtnL, BtnR, BtnD} = 4'b0;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    {BtnC, BtnL, BtnR, BtnD} = 4'b1111;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%03h exp=000", i, obs);
      end
    end
    do_reset();
  endtask

  task automatic test_press();
    int n_sel = 0;
    do_reset();
    BtnC = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      vectors++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL press_model cyc=%0d got=%03h exp=%03h", i, obs, model_out());
      end
      vectors++;
      if (Select !== (i == DEB + 3) || dpb[0] !== (i >= DEB + 3)) begin
        errors++;
        $display("FAIL press_latency cyc=%0d got sel=%b dpb0=%b exp sel=%b dpb0=%b",
                 i, Select, dpb[0], i == DEB + 3, i >= DEB + 3);
      end
      if (Select === 1'b1) n_sel++;
    end
    vectors++;
    if (n_sel !== 1) begin
      errors++;
      $display("FAIL press_count got=%0d exp=1", n_sel);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    do_reset();
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      BtnL = pat[i];
      tick();
      vectors++;
      if (selectLeft !== 1'b0 || obs !== model_out()) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%03h exp=%03h", i, obs, model_out());
      end
    end
    BtnL = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if (selectLeft !== (i == DEB + 3) || obs !== model_out()) begin
        errors++;
        $display("FAIL bounce_settle cyc=%0d got=%03h exp=%03h selL_exp=%b",
                 i, obs, model_out(), i == DEB + 3);
      end
    end
  endtask

  task automatic test_repeat();
    logic exp_m;
    do_reset();
    BtnR = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp_m = (i == DEB + 3) || (i >= DEB + 3 + RD && ((i - DEB - 3 - RD) % RP) == 0);
      vectors++;
      if (mcen[2] !== exp_m || selectRight !== (i == DEB + 3) || obs !== model_out()) begin
        errors++;
        $display("FAIL repeat cyc=%0d got mcen2=%b selR=%b all=%03h exp mcen2=%b all=%03h",
                 i, mcen[2], selectRight, obs, exp_m, model_out());
      end
    end
    BtnR = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      vectors++;
      if (dpb[2] !== (i < DEB + 3) || obs !== model_out()) begin
        errors++;
        $display("FAIL release cyc=%0d got dpb2=%b all=%03h exp dpb2=%b all=%03h",
                 i, dpb[2], obs, i < DEB + 3, model_out());
      end
    end
  endtask

  task automatic test_glitch();
    int n_quit = 0;
    int prev_rep = 0;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      BtnD = !(i == 11 || i == 12);
      tick();
      vectors++;
      if (obs !== model_out() || (i >= DEB + 3 && dpb[3] !== 1'b1)) begin
        errors++;
        $display("FAIL glitch cyc=%0d got=%03h exp=%03h", i, obs, model_out());
      end
      if (Quit === 1'b1) n_quit++;
      if (mcen[3] === 1'b1 && i > DEB + 3) begin
        if (prev_rep > 0) begin
          vectors++;
          if (i - prev_rep !== RP) begin
            errors++;
            $display("FAIL glitch_cadence cyc=%0d got gap=%0d exp=%0d", i, i - prev_rep, RP);
          end
        end
        prev_rep = i;
      end
    end
    vectors++;
    if (n_quit !== 1 || prev_rep == 0) begin
      errors++;
      $display("FAIL glitch_count got quit=%0d last_rep=%0d exp quit=1 with repeats", n_quit, prev_rep);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    BtnC = 1'b1;
    BtnR = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      vectors++;
      if ({Select, selectRight} !== {2{i == DEB + 3}} || obs !== model_out()) begin
        errors++;
        $display("FAIL simultaneous cyc=%0d got sel=%b selR=%b exp=%b", i, Select, selectRight,
                 i == DEB + 3);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    do_reset();
    BtnD = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (Quit !== 1'b0) begin
        errors++;
        $display("FAIL midreset_pre cyc=%0d got=%b exp=0", i, Quit);
      end
    end
    Reset = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      vectors++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL midreset_hold cyc=%0d got=%03h exp=000", i, obs);
      end
    end
    Reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors++;
      if (Quit !== (k == DEB + 3) || obs !== model_out()) begin
        errors++;
        $display("FAIL midreset_after cyc=%0d got quit=%b all=%03h exp quit=%b all=%03h",
                 k, Quit, obs, k == DEB + 3, model_out());
      end
    end
  endtask

  task automatic test_random();
    int left[4];
    logic [3:0] lvl;
    do_reset();
    lvl = 4'b0;
    for (int i = 0; i < 4; i++) left[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (left[i] == 0) begin
          lvl[i]  = 1'($urandom_range(0, 1));
          left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                 : int'($urandom_range(1, 7));
        end
        left[i]--;
      end
      {BtnD, BtnR, BtnL, BtnC} = lvl;
      Reset = ($urandom_range(0, 399) == 0);
      tick();
      vectors++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%03h exp=%03h", c, obs, model_out());
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_repeat();
    test_glitch();
    test_simultaneous();
    test_reset_mid_press();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
